pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Parametrised program-counter unit for the multi-cycle datapath. It replaces the bare increment-by-one adder with three parts: a registered PC, a next-PC selector (sequential, branch, jump, return, exception) and a small return-address stack (RAS). The PC is word-addressed and advances only when the controller asserts the PC write enable in the appropriate FSM state.

Parameters:
WIDTH, 32, PC width in bits; all PC arithmetic is modulo 2^WIDTH.
INC, 1, sequential increment (word addressing; 1 = next word).
RESET_PC, 0, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0040, PC loaded on exception (truncated to WIDTH).
RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_pc_we  input  1  PC update enable from the controller; the PC and RAS change only when this is 1.
i_sel  input  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 return.
i_target  input  WIDTH  branch/jump target; also the fallback for a return when the RAS is empty.
i_call  input  1  with i_pc_we: push o_pc_plus onto the RAS (call-type jump).
i_exc  input  1  with i_pc_we: load EXC_VECTOR; overrides i_sel and i_call.
o_pc  output  WIDTH  current PC (register output).
o_pc_plus  output  WIDTH  combinational o_pc + INC (link value).
o_ras_empty  output  1  RAS holds 0 valid entries.
o_ras_full  output  1  RAS holds RAS_DEPTH valid entries.
o_ras_underflow  output  1  one-cycle registered pulse: a return was taken while the RAS was empty.

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_pc = RESET_PC; RAS count = 0, top pointer = 0.
  - o_ras_empty = 1, o_ras_full = 0, o_ras_underflow = 0.
  - Reset has priority over every other input, including mid-sequence.
- i_pc_we=0: o_pc, RAS contents and count hold. o_ras_underflow = 0 on the next edge.
- i_pc_we=1 sets the next PC in the following priority order:
  1. i_exc=1 -> EXC_VECTOR. No RAS push or pop, even if i_call=1 or i_sel=11.
  2. i_sel=00 -> o_pc + INC (wraps: all-ones + 1 = 0).
  3. i_sel=01 or 10 -> i_target.
  4. i_sel=11 with RAS non-empty -> top entry; pop (count-1).
  5. i_sel=11 with RAS empty -> i_target; o_ras_underflow = 1 for one cycle; count stays 0.
- Latency: o_pc shows the new value one cycle after the enabled edge. o_pc_plus is combinational from o_pc.
- Call push (i_pc_we=1, i_call=1, i_exc=0):
  - Pushes o_pc_plus (the value before the update).
  - The push is independent of i_sel. i_sel=00 with i_call is legal (link to the next word, continue sequentially).
- RAS full on push: circular overwrite of the oldest entry. Count saturates at RAS_DEPTH; full stays 1. No error flag.
- Simultaneous call and return (i_sel=11, i_call=1):
  - Next PC = current top entry; the top entry is then replaced by o_pc_plus; count unchanged.
  - If the RAS is empty: next PC = i_target, underflow pulses, o_pc_plus is pushed (count becomes 1).
- The flags are derived from the registered count: empty = (count==0), full = (count==RAS_DEPTH).
- Stale RAS entries beyond count are never returned.

Optional Feature:
Macro PC_PERF_CNT_EN.
- Defined:
  - Adds output o_redirect_cnt [31:0], reset to 0.
  - Increments by 1 on each enabled update whose next PC is not o_pc + INC by selection, i.e. i_exc, or i_sel is 01, 10 or 11.
  - Wraps modulo 2^32; holds when i_pc_we=0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 enabled sequential updates (INC=1, RESET_PC=0) -> o_pc 0,1,2,3. With i_pc_we=0 for 2 cycles, o_pc holds at 3.
- o_pc=10, i_sel=10, i_call=1, i_target=100 -> o_pc=100, RAS count 1. Then i_sel=11 -> o_pc=11, o_ras_empty=1.
- Push 5 calls from PCs 0,1,2,3,4 (RAS_DEPTH=4):
  - o_ras_full=1 after the 4th push.
  - Returns give 5,4,3,2; a 5th return with i_target=77 gives o_pc=77 and a one-cycle o_ras_underflow pulse.
- i_exc=1 with i_sel=11, i_call=1, RAS count 2 -> o_pc=EXC_VECTOR, RAS count stays 2, no underflow.
- o_pc=32'hFFFF_FFFF, i_sel=00 -> o_pc=0. Assert i_rst mid-way through a call/return sequence -> o_pc=RESET_PC, o_ras_empty=1 on the next cycle.
- With PC_PERF_CNT_EN defined: sequence seq, branch, seq, jump, return, exc -> o_redirect_cnt=4.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered PC with next-PC selection and a circular return-address stack.
// Optional PC_PERF_CNT_EN adds o_redirect_cnt counting non-sequential updates.
module pc_next_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] INC        = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0040),
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pc_we,
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_call,
    input  logic             i_exc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus,
    output logic             o_ras_empty,
    output logic             o_ras_full,
    output logic             o_ras_underflow
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]      o_redirect_cnt
`endif
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] pc_n;
    logic             do_call;
    logic             do_ret;
    // ptr is the next free slot; the top entry sits just below it
    assign top         = ras[ptr - 1'b1];
    assign o_pc_plus   = o_pc + INC;
    assign o_ras_empty = (cnt == '0);
    assign o_ras_full  = (cnt == CW'(RAS_DEPTH));
    assign do_call     = i_pc_we & i_call & ~i_exc;
    assign do_ret      = i_pc_we & ~i_exc & (i_sel == 2'b11);
    always_comb begin
        pc_n = i_exc ? EXC_VECTOR
             : (i_sel == 2'b00) ? o_pc_plus
             : (i_sel == 2'b11 && !o_ras_empty) ? top
             : i_target;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pc            <= RESET_PC;
            ptr             <= '0;
            cnt             <= '0;
            o_ras_underflow <= 1'b0;
        end else begin
            o_ras_underflow <= do_ret & o_ras_empty;
            if (i_pc_we)
                o_pc <= pc_n;
            if (do_call && !(do_ret && !o_ras_empty)) begin
                ptr <= ptr + 1'b1;
                if (!o_ras_full)
                    cnt <= cnt + 1'b1;
            end else if (do_ret && !do_call && !o_ras_empty) begin
                ptr <= ptr - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end
    // a call+return on a non-empty stack replaces the entry it just consumed
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_call)
            ras[(do_ret && !o_ras_empty) ? ptr - 1'b1 : ptr] <= o_pc_plus;
    end
`ifdef PC_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_redirect_cnt <= '0;
        else if (i_pc_we && (i_exc || i_sel != 2'b00))
            o_redirect_cnt <= o_redirect_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: table-driven directed check of pc_next_unit with default parameters.
module tb_pc_next_unit;
    logic        clk = 1'b0;
    logic        rst, we, call, exc;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic [31:0] pc, pc_plus;
    logic        empty, full, uf;
`ifdef PC_PERF_CNT_EN
    logic [31:0] rcnt;
`endif
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst, we;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        call, exc;
        logic [31:0] pc;
        logic        e, f, u;
    } vec_t;
    vec_t v[$];

    pc_next_unit dut (
        .i_clk(clk), .i_rst(rst), .i_pc_we(we), .i_sel(sel), .i_target(tgt),
        .i_call(call), .i_exc(exc), .o_pc(pc), .o_pc_plus(pc_plus),
        .o_ras_empty(empty), .o_ras_full(full), .o_ras_underflow(uf)
`ifdef PC_PERF_CNT_EN
        , .o_redirect_cnt(rcnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic w, logic [1:0] s, logic [31:0] t, logic c, logic x,
                                logic [31:0] p, logic e, logic f, logic u);
        vec_t a;
        a.rst = r; a.we = w; a.sel = s; a.tgt = t; a.call = c; a.exc = x;
        a.pc = p; a.e = e; a.f = f; a.u = u;
        return a;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic [1:0] s, logic [31:0] t, logic c, logic x);
        rst = r; we = w; sel = s; tgt = t; call = c; exc = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; sel = 2'b00; tgt = '0; call = 1'b0; exc = 1'b0;
        //          rst we  sel    target        call exc  exp_pc        e  f  u
        v.push_back(mk(1, 0, 2'b00, 0,            0, 0, 0,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            0, 0, 1,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            0, 0, 2,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            0, 0, 3,            1, 0, 0));
        v.push_back(mk(0, 0, 2'b00, 55,           0, 0, 3,            1, 0, 0));
        v.push_back(mk(0, 0, 2'b01, 55,           1, 0, 3,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b01, 10,           0, 0, 10,           1, 0, 0));
        v.push_back(mk(0, 1, 2'b10, 100,          1, 0, 100,          0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 11,           1, 0, 0));
        v.push_back(mk(0, 1, 2'b01, 0,            0, 0, 0,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 1,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 2,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 3,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 4,            0, 1, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 5,            0, 1, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 5,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 4,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 3,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 2,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 77,           0, 0, 77,           1, 0, 1));
        v.push_back(mk(0, 0, 2'b11, 77,           0, 0, 77,           1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 78,           0, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 79,           0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 5,            1, 1, 32'h40,       0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 79,           0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 0,            0, 0, 78,           1, 0, 0));
        v.push_back(mk(0, 1, 2'b01, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            0, 0, 0,            1, 0, 0));
        // call+return together: non-empty swaps the top, empty pushes and underflows
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 1,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 9,            1, 0, 1,            0, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 9,            0, 0, 2,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 50,           1, 0, 50,           0, 0, 1));
        v.push_back(mk(0, 1, 2'b11, 9,            0, 0, 3,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b00, 0,            1, 0, 4,            0, 0, 0));
        v.push_back(mk(1, 1, 2'b11, 9,            1, 0, 0,            1, 0, 0));
        v.push_back(mk(0, 1, 2'b11, 9,            0, 0, 9,            1, 0, 1));

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].rst, v[i].we, v[i].sel, v[i].tgt, v[i].call, v[i].exc);
            chk($sformatf("v%0d pc", i), pc, v[i].pc);
            chk($sformatf("v%0d pc_plus", i), pc_plus, v[i].pc + 32'd1);
            chk($sformatf("v%0d empty", i), {31'b0, empty}, {31'b0, v[i].e});
            chk($sformatf("v%0d full", i), {31'b0, full}, {31'b0, v[i].f});
            chk($sformatf("v%0d underflow", i), {31'b0, uf}, {31'b0, v[i].u});
        end

`ifdef PC_PERF_CNT_EN
        drive(1, 0, 2'b00, 0, 0, 0);
        chk("perf reset", rcnt, 32'd0);
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b01, 20, 0, 0);
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 1, 2'b10, 30, 0, 0);
        drive(0, 1, 2'b11, 40, 0, 0);
        drive(0, 1, 2'b00, 0, 0, 1);
        chk("perf count", rcnt, 32'd4);
        drive(0, 0, 2'b01, 0, 0, 1);
        chk("perf hold", rcnt, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
